// File: rtl/lsu_dtcm_arb_pkg.sv
// Shared encodings and the outstanding-transaction record for the LSU/DTCM arbiter.
package lsu_dtcm_arb_pkg;

  typedef enum logic {
    SRC_AGU = 1'b0,
    SRC_EXT = 1'b1
  } lsu_src_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } lsu_size_e;

  localparam int OSTD_DEPTH_DEF = 2;

  // What the response path needs to route and align a reply; the itag rides alongside.
  typedef struct packed {
    lsu_src_e   src;
    logic       read;
    lsu_size_e  size;
    logic       usign;
    logic [1:0] off;
  } ostd_meta_t;

  localparam int META_W = $bits(ostd_meta_t);

endpackage

// File: rtl/lsu_dtcm_arb_ostd_fifo.sv
// In-order tracker of issued DTCM transactions: synchronous FIFO with full/empty flags.
module lsu_dtcm_arb_ostd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lsu_dtcm_arb.sv
// Shares the DTCM port between the AGU and an external requester: round-robin with
// stall lock, in-order response routing, and AGU load alignment/extension.
module lsu_dtcm_arb
  import lsu_dtcm_arb_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 2,
  parameter int OSTD_DEPTH      = OSTD_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         agu_cmd_valid,
  output logic                         agu_cmd_ready,
  input  logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr,
  input  logic                         agu_cmd_read,
  input  logic [XLEN-1:0]              agu_cmd_wdata,
  input  logic [XLEN/8-1:0]            agu_cmd_wmask,
  input  logic [ITAG_WIDTH-1:0]        agu_cmd_itag,
  input  logic                         agu_cmd_usign,
  input  logic [1:0]                   agu_cmd_size,
  output logic                         agu_rsp_valid,
  input  logic                         agu_rsp_ready,
  output logic [XLEN-1:0]              agu_rsp_rdata,
  output logic [ITAG_WIDTH-1:0]        agu_rsp_itag,
  output logic                         agu_rsp_read,
  input  logic                         ext_cmd_valid,
  output logic                         ext_cmd_ready,
  input  logic [DTCM_ADDR_WIDTH-1:0]   ext_cmd_addr,
  input  logic                         ext_cmd_read,
  input  logic [XLEN-1:0]              ext_cmd_wdata,
  input  logic [XLEN/8-1:0]            ext_cmd_wmask,
  output logic                         ext_rsp_valid,
  input  logic                         ext_rsp_ready,
  output logic [XLEN-1:0]              ext_rsp_rdata,
  output logic                         dtcm_cmd_valid,
  input  logic                         dtcm_cmd_ready,
  output logic [DTCM_ADDR_WIDTH-3:0]   dtcm_cmd_addr,
  output logic                         dtcm_cmd_read,
  output logic [XLEN-1:0]              dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]            dtcm_cmd_wmask,
  input  logic                         dtcm_rsp_valid,
  output logic                         dtcm_rsp_ready,
  input  logic [XLEN-1:0]              dtcm_rsp_rdata
);

  localparam int EW = ITAG_WIDTH + META_W;

  lsu_src_e              rr_ptr;
  lsu_src_e              lock_src;
  lsu_src_e              grant_src;
  logic                  lock;
  logic                  grant_valid;
  logic                  cmd_hs;
  logic                  rsp_hs;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  owner_rsp_ready;
  ostd_meta_t            push_meta;
  ostd_meta_t            head_meta;
  logic [ITAG_WIDTH-1:0] push_itag;
  logic [ITAG_WIDTH-1:0] head_itag;
  logic [EW-1:0]         head_entry;

  function automatic logic [XLEN-1:0] load_align(
    input logic [XLEN-1:0] rdata,
    input lsu_size_e       size,
    input logic            usign,
    input logic [1:0]      off
  );
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      SIZE_B:  return {{(XLEN-8){~usign & sh[7]}}, sh[7:0]};
      SIZE_H:  return {{(XLEN-16){~usign & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // A stalled request keeps its grant so the presented command cannot change under the SRAM.
  always_comb begin
    grant_src = rr_ptr;
    if (lock)                                grant_src = lock_src;
    else if (agu_cmd_valid && !ext_cmd_valid) grant_src = SRC_AGU;
    else if (ext_cmd_valid && !agu_cmd_valid) grant_src = SRC_EXT;
  end

  assign grant_valid    = (grant_src == SRC_EXT) ? ext_cmd_valid : agu_cmd_valid;
  assign dtcm_cmd_valid = grant_valid && !fifo_full;
  assign cmd_hs         = dtcm_cmd_valid && dtcm_cmd_ready;
  assign agu_cmd_ready  = cmd_hs && (grant_src == SRC_AGU);
  assign ext_cmd_ready  = cmd_hs && (grant_src == SRC_EXT);

  assign dtcm_cmd_addr  = (grant_src == SRC_EXT) ? ext_cmd_addr[DTCM_ADDR_WIDTH-1:2]
                                                 : agu_cmd_addr[DTCM_ADDR_WIDTH-1:2];
  assign dtcm_cmd_read  = (grant_src == SRC_EXT) ? ext_cmd_read  : agu_cmd_read;
  assign dtcm_cmd_wdata = (grant_src == SRC_EXT) ? ext_cmd_wdata : agu_cmd_wdata;
  assign dtcm_cmd_wmask = (grant_src == SRC_EXT) ? ext_cmd_wmask : agu_cmd_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= SRC_AGU;
      lock     <= 1'b0;
      lock_src <= SRC_AGU;
    end else begin
      lock <= dtcm_cmd_valid && !dtcm_cmd_ready;
      if (dtcm_cmd_valid && !dtcm_cmd_ready) lock_src <= grant_src;
      if (cmd_hs) rr_ptr <= (grant_src == SRC_AGU) ? SRC_EXT : SRC_AGU;
    end
  end

  // External accesses are raw words, so size/usign are fixed for them.
  always_comb begin
    push_meta.src   = grant_src;
    push_meta.read  = dtcm_cmd_read;
    push_meta.size  = (grant_src == SRC_EXT) ? SIZE_W : lsu_size_e'(agu_cmd_size);
    push_meta.usign = (grant_src == SRC_EXT) ? 1'b0 : agu_cmd_usign;
    push_meta.off   = (grant_src == SRC_EXT) ? ext_cmd_addr[1:0] : agu_cmd_addr[1:0];
    push_itag       = (grant_src == SRC_EXT) ? '0 : agu_cmd_itag;
  end

  lsu_dtcm_arb_ostd_fifo #(
    .WIDTH (EW),
    .DEPTH (OSTD_DEPTH)
  ) u_ostd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_hs),
    .push_data ({push_itag, push_meta}),
    .pop       (rsp_hs),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_meta = head_entry[META_W-1:0];
  assign head_itag = head_entry[EW-1:META_W];

  // The head owner gates the SRAM response; the other requester waits behind it.
  assign owner_rsp_ready = (head_meta.src == SRC_EXT) ? ext_rsp_ready : agu_rsp_ready;
  assign dtcm_rsp_ready  = !fifo_empty && owner_rsp_ready;
  assign rsp_hs          = dtcm_rsp_valid && dtcm_rsp_ready;

  assign agu_rsp_valid = dtcm_rsp_valid && !fifo_empty && (head_meta.src == SRC_AGU);
  assign ext_rsp_valid = dtcm_rsp_valid && !fifo_empty && (head_meta.src == SRC_EXT);
  assign agu_rsp_read  = head_meta.read;
  assign agu_rsp_itag  = head_itag;
  assign agu_rsp_rdata = head_meta.read ? load_align(dtcm_rsp_rdata, head_meta.size,
                                                     head_meta.usign, head_meta.off)
                                        : '0;
  assign ext_rsp_rdata = dtcm_rsp_rdata;

endmodule

// File: tb/tb_lsu_dtcm_arb.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_lsu_dtcm_arb;

  localparam int XLEN  = 32;
  localparam int AW    = 16;
  localparam int IW    = 2;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [AW-1:0]   agu_cmd_addr;
  logic [31:0]     agu_cmd_wdata;
  logic [3:0]      agu_cmd_wmask;
  logic [IW-1:0]   agu_cmd_itag;
  logic [1:0]      agu_cmd_size;
  logic            agu_rsp_valid, agu_rsp_ready, agu_rsp_read;
  logic [31:0]     agu_rsp_rdata;
  logic [IW-1:0]   agu_rsp_itag;
  logic            ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
  logic [AW-1:0]   ext_cmd_addr;
  logic [31:0]     ext_cmd_wdata;
  logic [3:0]      ext_cmd_wmask;
  logic            ext_rsp_valid, ext_rsp_ready;
  logic [31:0]     ext_rsp_rdata;
  logic            dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [AW-3:0]   dtcm_cmd_addr;
  logic [31:0]     dtcm_cmd_wdata;
  logic [3:0]      dtcm_cmd_wmask;
  logic            dtcm_rsp_valid, dtcm_rsp_ready;
  logic [31:0]     dtcm_rsp_rdata;

  always #5 clk = ~clk;

  lsu_dtcm_arb #(
    .XLEN(XLEN), .DTCM_ADDR_WIDTH(AW), .ITAG_WIDTH(IW), .OSTD_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_addr(agu_cmd_addr),
    .agu_cmd_read(agu_cmd_read), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_itag(agu_cmd_itag), .agu_cmd_usign(agu_cmd_usign), .agu_cmd_size(agu_cmd_size),
    .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready), .agu_rsp_rdata(agu_rsp_rdata),
    .agu_rsp_itag(agu_rsp_itag), .agu_rsp_read(agu_rsp_read),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_addr(ext_cmd_addr),
    .ext_cmd_read(ext_cmd_read), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_addr(dtcm_cmd_addr),
    .dtcm_cmd_read(dtcm_cmd_read), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    agu_cmd_valid = 0; agu_cmd_addr = '0; agu_cmd_read = 0; agu_cmd_wdata = '0;
    agu_cmd_wmask = '0; agu_cmd_itag = '0; agu_cmd_usign = 0; agu_cmd_size = 2'b10;
    ext_cmd_valid = 0; ext_cmd_addr = '0; ext_cmd_read = 0; ext_cmd_wdata = '0; ext_cmd_wmask = '0;
    agu_rsp_ready = 0; ext_rsp_ready = 0;
    dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;
  endtask

  task automatic reset_dut();
    rst = 1;
    idle();
    step();
    step();
    rst = 0;
  endtask

  // Issue one command from a single requester with the SRAM ready; checks acceptance and the muxed fields.
  task automatic issue(input bit src, input logic [15:0] addr, input bit rd, input logic [1:0] size,
                       input bit usign, input logic [1:0] itag, input logic [31:0] wdata,
                       input logic [3:0] wmask, input string tag);
    if (src) begin
      ext_cmd_valid = 1; ext_cmd_addr = addr; ext_cmd_read = rd;
      ext_cmd_wdata = wdata; ext_cmd_wmask = wmask;
    end else begin
      agu_cmd_valid = 1; agu_cmd_addr = addr; agu_cmd_read = rd; agu_cmd_size = size;
      agu_cmd_usign = usign; agu_cmd_itag = itag; agu_cmd_wdata = wdata; agu_cmd_wmask = wmask;
    end
    dtcm_cmd_ready = 1;
    @(negedge clk);
    check({tag, "_rdy"}, 64'({agu_cmd_ready, ext_cmd_ready}), 64'({!src, src}));
    check({tag, "_cmd"}, 64'({dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata, dtcm_cmd_wmask}),
          64'({addr[15:2], rd, wdata, wmask}));
    step();
    agu_cmd_valid = 0; ext_cmd_valid = 0; dtcm_cmd_ready = 0;
  endtask

  task automatic resp(input bit src, input logic [31:0] rdata, input logic [31:0] exp_data,
                      input logic [1:0] exp_itag, input bit exp_rd, input string tag);
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = rdata; agu_rsp_ready = 1; ext_rsp_ready = 1;
    @(negedge clk);
    check({tag, "_vld"}, 64'({agu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready}), 64'({!src, src, 1'b1}));
    if (src) check({tag, "_data"}, 64'(ext_rsp_rdata), 64'(exp_data));
    else     check({tag, "_data"}, 64'({agu_rsp_itag, agu_rsp_read, agu_rsp_rdata}),
                   64'({exp_itag, exp_rd, exp_data}));
    step();
    dtcm_rsp_valid = 0;
  endtask

  // Load result from the byte lane arithmetic: pick the lanes, then sign-fill by value range.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input bit usign, input logic [1:0] off);
    int unsigned v;
    v = w >> (8 * off);
    if (size == 2'b00) begin
      v = v % 256;
      if (!usign && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = v % 65536;
      if (!usign && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  typedef struct {
    bit          src;
    logic [1:0]  itag;
    bit          read;
    logic [1:0]  size;
    bit          usign;
    logic [1:0]  off;
    logic [31:0] rdata;
  } txn_t;

  txn_t        pend[$];
  logic [31:0] mem [64];
  bit          m_rr, m_lock, m_lock_src, m_agu_hs, m_ext_hs;

  initial begin
    reset_dut();
    // Empty tracker: nothing may be forwarded or accepted even with every ready/valid high.
    dtcm_rsp_valid = 1; agu_rsp_ready = 1; ext_rsp_ready = 1; dtcm_cmd_ready = 1;
    @(negedge clk);
    check("reset_outputs", 64'({agu_cmd_ready, ext_cmd_ready, dtcm_cmd_valid,
                                agu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready}), 64'd0);
    step();
    idle();

    issue(0, 16'h0003, 1, 2'b00, 0, 2'd2, 32'h0, 4'h0, "t1_lb");
    resp(0, 32'h80FF_0000, 32'hFFFF_FF80, 2'd2, 1, "t1_lb_rsp");

    issue(0, 16'h0002, 1, 2'b01, 1, 2'd1, 32'h0, 4'h0, "t2_lhu");
    issue(0, 16'h0004, 0, 2'b10, 0, 2'd3, 32'hAABB_CCDD, 4'hF, "t2_sw");
    resp(0, 32'h8001_1234, 32'h0000_8001, 2'd1, 1, "t2_lhu_rsp");
    resp(0, 32'hDEAD_BEEF, 32'h0, 2'd3, 0, "t2_sw_rsp");

    // Outstanding limit, and the slot freed by a pop only becomes usable next cycle.
    agu_cmd_valid = 1; agu_cmd_addr = 16'h0008; agu_cmd_read = 1; agu_cmd_size = 2'b10;
    agu_cmd_usign = 0; agu_cmd_itag = 0; dtcm_cmd_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_accept", 64'(agu_cmd_ready), 64'd1);
      step();
    end
    @(negedge clk);
    check("t4_full", 64'({agu_cmd_ready, dtcm_cmd_valid}), 64'd0);
    step();
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h1122_3344; agu_rsp_ready = 1;
    @(negedge clk);
    check("t4_no_bypass", 64'({agu_rsp_valid, agu_cmd_ready}), 64'b10);
    step();
    dtcm_rsp_valid = 0;
    @(negedge clk);
    check("t4_slot_freed", 64'(agu_cmd_ready), 64'd1);
    step();
    agu_cmd_valid = 0; dtcm_cmd_ready = 0;
    resp(0, 32'h1122_3344, 32'h1122_3344, 2'd0, 1, "t4_drain0");
    resp(0, 32'h1122_3344, 32'h1122_3344, 2'd0, 1, "t4_drain1");

    // Alternation from a fresh reset with both sides always requesting.
    reset_dut();
    agu_cmd_valid = 1; agu_cmd_addr = 16'h0010; agu_cmd_read = 1;
    ext_cmd_valid = 1; ext_cmd_addr = 16'h0020; ext_cmd_read = 1;
    dtcm_cmd_ready = 1; dtcm_rsp_valid = 1; agu_rsp_ready = 1; ext_rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t3_grant%0d", k), 64'({agu_cmd_ready, ext_cmd_ready}),
            (k % 2 == 0) ? 64'b10 : 64'b01);
      step();
    end
    agu_cmd_valid = 0; ext_cmd_valid = 0;
    step();
    idle();

    // Point rr at EXT so only the lock keeps the stalled AGU request granted.
    issue(0, 16'h0040, 1, 2'b10, 0, 2'd1, 32'h0, 4'h0, "t5_pre");
    resp(0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'd1, 1, "t5_pre_rsp");
    agu_cmd_valid = 1; agu_cmd_addr = 16'h0030; agu_cmd_read = 1; agu_cmd_size = 2'b10;
    agu_cmd_itag = 2'd2; agu_cmd_usign = 0;
    @(negedge clk);
    check("t5_first", 64'({dtcm_cmd_valid, dtcm_cmd_addr}), 64'({1'b1, 14'h000C}));
    step();
    ext_cmd_valid = 1; ext_cmd_addr = 16'h0050; ext_cmd_read = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t5_lock%0d", k), 64'({dtcm_cmd_valid, dtcm_cmd_addr, agu_cmd_ready, ext_cmd_ready}),
            64'({1'b1, 14'h000C, 2'b00}));
      step();
    end
    dtcm_cmd_ready = 1;
    @(negedge clk);
    check("t5_release", 64'({agu_cmd_ready, ext_cmd_ready}), 64'b10);
    step();
    agu_cmd_valid = 0;
    @(negedge clk);
    check("t5_ext_next", 64'({ext_cmd_ready, dtcm_cmd_addr}), 64'({1'b1, 14'h0014}));
    step();
    ext_cmd_valid = 0; dtcm_cmd_ready = 0;
    resp(0, 32'h0102_0304, 32'h0102_0304, 2'd2, 1, "t5_rsp_agu");
    resp(1, 32'h5566_7788, 32'h5566_7788, 2'd0, 0, "t5_rsp_ext");

    // Response to a transaction issued before reset must be dropped.
    issue(0, 16'h0060, 1, 2'b10, 0, 2'd3, 32'h0, 4'h0, "t6_pre");
    rst = 1;
    step();
    rst = 0;
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h1234_5678; agu_rsp_ready = 1; ext_rsp_ready = 1;
    @(negedge clk);
    check("t6_drop", 64'({agu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready}), 64'd0);
    step();
    idle();
    issue(1, 16'h0070, 1, 2'b10, 0, 2'd0, 32'h0, 4'h0, "t6_ext");
    issue(0, 16'h0074, 1, 2'b00, 1, 2'd1, 32'h0, 4'h0, "t6_agu");
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h9ABC_DEF0; ext_rsp_ready = 0; agu_rsp_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("t6_hol%0d", k), 64'({agu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready}), 64'b010);
      step();
    end
    resp(1, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 2'd0, 0, "t6_ext_rsp");
    resp(0, 32'h1234_56A5, 32'h0000_00A5, 2'd1, 1, "t6_agu_rsp");

    // Randomized traffic against the transaction-level model.
    reset_dut();
    pend.delete();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    m_rr = 0; m_lock = 0; m_lock_src = 0; m_agu_hs = 0; m_ext_hs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit   both, exp_valid, exp_src, exp_rr, cmd_hs, rsp_hs;
      txn_t t;
      if (m_agu_hs) agu_cmd_valid = 0;
      if (m_ext_hs) ext_cmd_valid = 0;
      if (!agu_cmd_valid && $urandom_range(0, 99) < 60) begin
        agu_cmd_valid = 1; agu_cmd_addr = 16'($urandom_range(0, 255)); agu_cmd_read = 1'($urandom);
        agu_cmd_size = 2'($urandom); agu_cmd_usign = 1'($urandom); agu_cmd_itag = 2'($urandom);
        agu_cmd_wdata = $urandom; agu_cmd_wmask = 4'($urandom);
      end
      if (!ext_cmd_valid && $urandom_range(0, 99) < 50) begin
        ext_cmd_valid = 1; ext_cmd_addr = 16'($urandom_range(0, 255)); ext_cmd_read = 1'($urandom);
        ext_cmd_wdata = $urandom; ext_cmd_wmask = 4'($urandom);
      end
      dtcm_cmd_ready = ($urandom_range(0, 99) < 70);
      if (pend.size() > 0 && $urandom_range(0, 99) < 60) begin
        dtcm_rsp_valid = 1; dtcm_rsp_rdata = pend[0].rdata;
      end else begin
        dtcm_rsp_valid = 0; dtcm_rsp_rdata = $urandom;
      end
      agu_rsp_ready = ($urandom_range(0, 99) < 75);
      ext_rsp_ready = ($urandom_range(0, 99) < 75);

      @(negedge clk);
      both      = agu_cmd_valid && ext_cmd_valid;
      exp_src   = m_lock ? m_lock_src : (both ? m_rr : ext_cmd_valid);
      exp_valid = (agu_cmd_valid || ext_cmd_valid) && (pend.size() < DEPTH);
      check("rnd_cmd_valid", 64'(dtcm_cmd_valid), 64'(exp_valid));
      if (exp_valid) begin
        if (exp_src) check("rnd_cmd_ext", 64'({dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata, dtcm_cmd_wmask}),
                           64'({ext_cmd_addr[15:2], ext_cmd_read, ext_cmd_wdata, ext_cmd_wmask}));
        else         check("rnd_cmd_agu", 64'({dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata, dtcm_cmd_wmask}),
                           64'({agu_cmd_addr[15:2], agu_cmd_read, agu_cmd_wdata, agu_cmd_wmask}));
      end
      cmd_hs = exp_valid && dtcm_cmd_ready;
      check("rnd_src_ready", 64'({agu_cmd_ready, ext_cmd_ready}),
            64'({cmd_hs && !exp_src, cmd_hs && exp_src}));

      rsp_hs = 0;
      if (pend.size() == 0) begin
        check("rnd_rsp_idle", 64'({agu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready}), 64'd0);
      end else begin
        t      = pend[0];
        exp_rr = t.src ? ext_rsp_ready : agu_rsp_ready;
        check("rnd_rsp_route", 64'({agu_rsp_valid, ext_rsp_valid, dtcm_rsp_ready}),
              64'({dtcm_rsp_valid && !t.src, dtcm_rsp_valid && t.src, exp_rr}));
        if (dtcm_rsp_valid && !t.src)
          check("rnd_agu_rsp", 64'({agu_rsp_itag, agu_rsp_read, agu_rsp_rdata}),
                64'({t.itag, t.read, t.read ? ref_load(t.rdata, t.size, t.usign, t.off) : 32'h0}));
        if (dtcm_rsp_valid && t.src)
          check("rnd_ext_rsp", 64'(ext_rsp_rdata), 64'(t.rdata));
        rsp_hs = dtcm_rsp_valid && exp_rr;
      end

      if (rsp_hs) void'(pend.pop_front());
      m_agu_hs = cmd_hs && !exp_src;
      m_ext_hs = cmd_hs && exp_src;
      if (cmd_hs) begin
        logic [15:0] a;
        logic [31:0] wd;
        logic [3:0]  wm;
        t.src   = exp_src;
        a       = exp_src ? ext_cmd_addr : agu_cmd_addr;
        t.read  = exp_src ? ext_cmd_read : agu_cmd_read;
        t.size  = exp_src ? 2'b10 : agu_cmd_size;
        t.usign = exp_src ? 1'b0 : agu_cmd_usign;
        t.itag  = exp_src ? 2'd0 : agu_cmd_itag;
        t.off   = a[1:0];
        wd      = exp_src ? ext_cmd_wdata : agu_cmd_wdata;
        wm      = exp_src ? ext_cmd_wmask : agu_cmd_wmask;
        t.rdata = t.read ? mem[a[7:2]] : $urandom;
        if (!t.read)
          for (int b = 0; b < 4; b++) if (wm[b]) mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
        pend.push_back(t);
        m_rr = !exp_src;
      end
      m_lock = exp_valid && !dtcm_cmd_ready;
      if (m_lock) m_lock_src = exp_src;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
